// File: rtl/enigma_pkg.sv
// enigma_pkg: shared block geometry, types and flat byte-index mapping for the cipher datapath
package enigma_pkg;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int BLK_BYTES = 16;
    typedef logic [7:0] byte_t;
    typedef byte_t [15:0] block_t;
    typedef enum logic {FILL, FULL} loader_st_t;
    function automatic logic [3:0] idx(input int row, input int col);
        return 4'(COLS * row + col);
    endfunction
endpackage

// File: rtl/state_loader.sv
// state_loader: assembles sixteen serial bytes plus a direction flag into one parallel state block
module state_loader
    import enigma_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     in_dir,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLK_BYTES*DATA_W-1:0] out_state,
    output logic                     out_dir,
    output logic                     err
);
    loader_st_t st, st_nx;
    logic [3:0] cnt, cnt_nx;
    logic rdy_nx, ov_nx, err_nx;
    logic acc_in, acc_out;
    block_t blk;
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;
    assign out_state = blk;
    // FSM, byte counter and registered handshake/error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= FILL;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            st        <= st_nx;
            cnt       <= cnt_nx;
            in_ready  <= rdy_nx;
            out_valid <= ov_nx;
            err       <= err_nx;
        end
    end
    // Next state: take bytes in FILL, drop malformed blocks, hold a good block in FULL until taken
    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        rdy_nx = in_ready;
        ov_nx  = out_valid;
        err_nx = 1'b0;
        case (st)
            FILL: begin
                rdy_nx = 1'b1;
                if (acc_in) begin
                    if (in_last && cnt == 4'd15) begin
                        st_nx  = FULL;
                        ov_nx  = 1'b1;
                        rdy_nx = 1'b0;
                        cnt_nx = '0;
                    end else if (in_last || cnt == 4'd15) begin
                        err_nx = 1'b1;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            FULL: begin
                if (acc_out) begin
                    st_nx  = FILL;
                    ov_nx  = 1'b0;
                    rdy_nx = 1'b1;
                    cnt_nx = '0;
                end
            end
            default: st_nx = FILL;
        endcase
    end
    // Byte register file and direction capture; writes only on input accepts, so FULL holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk     <= '0;
            out_dir <= 1'b0;
        end else if (acc_in) begin
            blk[cnt] <= in_data;
            if (cnt == 4'd0) out_dir <= in_dir;
        end
    end
endmodule

// File: tb/tb_state_loader.sv
// tb_state_loader: directed self-checking bench for the serial-to-parallel state loader
module tb_state_loader;
    import enigma_pkg::*;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_last, in_dir, out_valid, out_ready, out_dir, err;
    logic [7:0] in_data;
    logic [127:0] out_state;
    int passed = 0;
    int total = 0;

    state_loader #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_dir(in_dir), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_dir(out_dir), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] blk_of(input logic [7:0] base);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input logic dir);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", 128'(n < 50), 128'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_dir   = dir;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] base, input int n, input int last_at,
                              input logic dir, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(base + 8'(i), i == last_at, i == 0 ? dir : ~dir);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_dir = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_state", out_state, 128'(0));
        check("rst_out_dir", 128'(out_dir), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 128'(in_ready), 128'(1));

        // basic block, downstream always ready
        out_ready = 1'b1;
        send_block(8'h00, 16, 15, 1'b1, 1'b0);
        check("t1_out_valid", 128'(out_valid), 128'(1));
        check("t1_in_ready_low", 128'(in_ready), 128'(0));
        check("t1_a0", 128'(out_state[8*idx(0, 0) +: 8]), 128'(8'h00));
        check("t1_b0", 128'(out_state[8*idx(1, 0) +: 8]), 128'(8'h04));
        check("t1_d3", 128'(out_state[8*idx(3, 3) +: 8]), 128'(8'h0F));
        check("t1_state", out_state, blk_of(8'h00));
        check("t1_out_dir", 128'(out_dir), 128'(1));
        check("t1_err", 128'(err), 128'(0));
        @(negedge clk);
        check("t1_valid_one_cycle", 128'(out_valid), 128'(0));
        check("t1_in_ready_back", 128'(in_ready), 128'(1));

        // backpressure with in_valid held high
        out_ready = 1'b0;
        send_block(8'h00, 16, 15, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            check("t2_in_ready_low", 128'(in_ready), 128'(0));
            check("t2_out_valid", 128'(out_valid), 128'(1));
            check("t2_state_held", out_state, blk_of(8'h00));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_released_valid", 128'(out_valid), 128'(0));
        check("t2_released_ready", 128'(in_ready), 128'(1));

        // early last on byte 7, then a clean block with direction 0
        send_block(8'h00, 8, 7, 1'b1, 1'b0);
        check("t3_err", 128'(err), 128'(1));
        check("t3_no_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("t3_err_one_cycle", 128'(err), 128'(0));
        check("t3_still_no_valid", 128'(out_valid), 128'(0));
        send_block(8'h10, 16, 15, 1'b0, 1'b0);
        check("t3_valid", 128'(out_valid), 128'(1));
        check("t3_a0", 128'(out_state[7:0]), 128'(8'h10));
        check("t3_state", out_state, blk_of(8'h10));
        check("t3_out_dir", 128'(out_dir), 128'(0));
        @(negedge clk);

        // missing last: sixteen bytes without in_last
        send_block(8'h20, 16, -1, 1'b1, 1'b0);
        check("t4_err", 128'(err), 128'(1));
        check("t4_no_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("t4_err_one_cycle", 128'(err), 128'(0));
        send_block(8'h30, 16, 15, 1'b1, 1'b0);
        check("t4_valid", 128'(out_valid), 128'(1));
        check("t4_state", out_state, blk_of(8'h30));
        @(negedge clk);

        // reset after nine bytes
        send_block(8'h40, 9, -1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_in_ready", 128'(in_ready), 128'(0));
        check("t5_out_valid", 128'(out_valid), 128'(0));
        check("t5_out_state", out_state, 128'(0));
        check("t5_out_dir", 128'(out_dir), 128'(0));
        check("t5_err", 128'(err), 128'(0));
        @(negedge clk);
        check("t5_in_ready_held", 128'(in_ready), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        send_block(8'hA0, 16, 15, 1'b1, 1'b0);
        check("t5_valid", 128'(out_valid), 128'(1));
        check("t5_d3", 128'(out_state[8*idx(3, 3) +: 8]), 128'(8'hAF));
        check("t5_state", out_state, blk_of(8'hA0));
        @(negedge clk);

        // random gaps between bytes
        out_ready = 1'b0;
        send_block(8'h00, 16, 15, 1'b1, 1'b1);
        check("t6_valid", 128'(out_valid), 128'(1));
        check("t6_state", out_state, blk_of(8'h00));
        check("t6_out_dir", 128'(out_dir), 128'(1));
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_released", 128'(out_valid), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
